// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
// The fetch stage drives the request and address. The memory answers with a
// valid strobe and the instruction word.
interface instruction_fetch_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) ();

   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic                  imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage plus IF/ID pipeline register for the 16-bit CPU.
// It keeps a single request outstanding to instruction memory and absorbs
// memory wait states. A one-entry skid buffer holds a returned instruction
// while decode is stalled. Taken branches redirect the PC. A request that is
// in flight when a branch is taken is drained and its data is discarded.
module instruction_fetch #(
   parameter int                    PC_WIDTH    = 16,
   parameter int                    INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   instruction_fetch_if.master      imem,
   input  logic                     stall,
   input  logic                     branch_taken,
   input  logic [PC_WIDTH-1:0]      branch_target,
   output logic [INSTR_WIDTH-1:0]   if_id_instr,
   output logic [PC_WIDTH-1:0]      if_id_pc_next,
   output logic                     if_id_valid
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetchState_t;

   localparam logic [PC_WIDTH-1:0] PcStep  = PC_WIDTH'(2);
   localparam logic [PC_WIDTH-1:0] LsbMask = ~PC_WIDTH'(1);

   fetchState_t            state, nextState;
   logic [PC_WIDTH-1:0]    pc, nextPc;
   logic [PC_WIDTH-1:0]    drainAddr, nextDrainAddr;
   logic [INSTR_WIDTH-1:0] skidInstr, nextSkidInstr;
   logic [PC_WIDTH-1:0]    skidPcNext, nextSkidPcNext;
   logic                   skidValid, nextSkidValid;
   logic [INSTR_WIDTH-1:0] ifIdInstr, nextIfIdInstr;
   logic [PC_WIDTH-1:0]    ifIdPcNext, nextIfIdPcNext;
   logic                   ifIdValid, nextIfIdValid;
   logic [PC_WIDTH-1:0]    pcPlusTwo;
   logic [PC_WIDTH-1:0]    alignedTarget;

   assign pcPlusTwo     = pc + PcStep;
   assign alignedTarget = branch_target & LsbMask;

   // While draining, the old address stays on the bus until the memory
   // answers. Otherwise the bus shows the current PC.
   assign imem.imem_req  = (state == REQ) || (state == DRAIN);
   assign imem.imem_addr = (state == DRAIN) ? drainAddr : pc;

   assign if_id_instr   = ifIdInstr;
   assign if_id_pc_next = ifIdPcNext;
   assign if_id_valid   = ifIdValid;

   // Next-state and datapath decisions. A branch outranks stall and
   // response capture in every state.
   always_comb begin
      nextState      = state;
      nextPc         = pc;
      nextDrainAddr  = drainAddr;
      nextSkidInstr  = skidInstr;
      nextSkidPcNext = skidPcNext;
      nextSkidValid  = skidValid;
      nextIfIdInstr  = ifIdInstr;
      nextIfIdPcNext = ifIdPcNext;
      nextIfIdValid  = ifIdValid;
      case (state)
         IDLE: begin
            nextState = REQ;
            if (branch_taken) begin
               nextPc        = alignedTarget;
               nextIfIdValid = 1'b0;
               nextSkidValid = 1'b0;
            end
         end
         REQ: begin
            if (branch_taken) begin
               nextPc        = alignedTarget;
               nextIfIdValid = 1'b0;
               nextSkidValid = 1'b0;
               if (!imem.imem_valid) begin
                  nextState     = DRAIN;
                  nextDrainAddr = pc;
               end
            end else if (imem.imem_valid) begin
               nextPc = pcPlusTwo;
               if (stall) begin
                  nextSkidInstr  = imem.imem_rdata;
                  nextSkidPcNext = pcPlusTwo;
                  nextSkidValid  = 1'b1;
                  nextState      = HOLD;
               end else begin
                  nextIfIdInstr  = imem.imem_rdata;
                  nextIfIdPcNext = pcPlusTwo;
                  nextIfIdValid  = 1'b1;
               end
            end else if (!stall) begin
               nextIfIdValid = 1'b0;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               nextPc        = alignedTarget;
               nextIfIdValid = 1'b0;
               nextSkidValid = 1'b0;
               nextState     = REQ;
            end else if (!stall) begin
               nextIfIdInstr  = skidInstr;
               nextIfIdPcNext = skidPcNext;
               nextIfIdValid  = skidValid;
               nextSkidValid  = 1'b0;
               nextState      = REQ;
            end
         end
         DRAIN: begin
            nextIfIdValid = 1'b0;
            if (branch_taken) begin
               nextPc = alignedTarget;
            end
            if (imem.imem_valid) begin
               nextState = REQ;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State, PC, skid buffer and IF/ID registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         drainAddr  <= '0;
         skidInstr  <= '0;
         skidPcNext <= '0;
         skidValid  <= 1'b0;
         ifIdInstr  <= '0;
         ifIdPcNext <= '0;
         ifIdValid  <= 1'b0;
      end else begin
         state      <= nextState;
         pc         <= nextPc;
         drainAddr  <= nextDrainAddr;
         skidInstr  <= nextSkidInstr;
         skidPcNext <= nextSkidPcNext;
         skidValid  <= nextSkidValid;
         ifIdInstr  <= nextIfIdInstr;
         ifIdPcNext <= nextIfIdPcNext;
         ifIdValid  <= nextIfIdValid;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch. A behavioural memory with configurable
// wait states serves requests. A transaction-level reference model tracks
// the PC, the pending discard, buffered instructions and the IF/ID contents.
module tb_instruction_fetch;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pcNext;
   } bufEntry_t;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_next;
   logic        if_id_valid;

   instruction_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   instruction_fetch #(
      .PC_WIDTH(16),
      .INSTR_WIDTH(16),
      .RESET_PC(16'h0000)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem(bus.master),
      .stall(stall),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .if_id_instr(if_id_instr),
      .if_id_pc_next(if_id_pc_next),
      .if_id_valid(if_id_valid)
   );

   int compareCount = 0;
   int failCount    = 0;

   logic [15:0] memArr [0:255];
   bit          memActive;
   int          memCnt;
   int          memWaitCur;
   int          memFixedWait = 0;
   int          memMaxWait   = 3;
   logic [15:0] memTxnAddr;

   bit          mStarted;
   logic [15:0] mPc;
   bit          mDraining;
   logic [15:0] mDrainAddr;
   bufEntry_t   mBuf [$];
   logic        mIfValid;
   logic [15:0] mIfInstr;
   logic [15:0] mIfPcNext;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mStarted  = 1'b0;
      mPc       = 16'h0000;
      mDraining = 1'b0;
      mDrainAddr = 16'h0000;
      mBuf.delete();
      mIfValid  = 1'b0;
      mIfInstr  = 16'h0000;
      mIfPcNext = 16'h0000;
   endtask

   // Advance the reference model by one clock edge using the inputs seen at that edge.
   task automatic modelStep(input bit r, input bit s, input bit b, input logic [15:0] t,
                            input bit v, input logic [15:0] d);
      logic [15:0] tgt;
      bufEntry_t   e;
      tgt = {t[15:1], 1'b0};
      if (!r) begin
         modelReset();
      end else if (!mStarted) begin
         mStarted = 1'b1;
         if (b) begin
            mPc = tgt;
            mIfValid = 1'b0;
         end
      end else if (mBuf.size() > 0) begin
         if (b) begin
            mBuf.delete();
            mIfValid = 1'b0;
            mPc = tgt;
         end else if (!s) begin
            e = mBuf.pop_front();
            mIfInstr  = e.instr;
            mIfPcNext = e.pcNext;
            mIfValid  = 1'b1;
         end
      end else if (mDraining) begin
         mIfValid = 1'b0;
         if (b) mPc = tgt;
         if (v) mDraining = 1'b0;
      end else begin
         if (b) begin
            mIfValid = 1'b0;
            if (!v) begin
               mDraining  = 1'b1;
               mDrainAddr = mPc;
            end
            mPc = tgt;
         end else if (v) begin
            if (s) begin
               e.instr  = d;
               e.pcNext = mPc + 16'd2;
               mBuf.push_back(e);
            end else begin
               mIfInstr  = d;
               mIfPcNext = mPc + 16'd2;
               mIfValid  = 1'b1;
            end
            mPc = mPc + 16'd2;
         end else if (!s) begin
            mIfValid = 1'b0;
         end
      end
   endtask

   // One clock cycle. Check the bus at the falling edge, then drive inputs
   // and the memory response. After the rising edge, advance the model and
   // check the registered outputs.
   task automatic applyStimulus(input bit rstIn, input bit stallIn, input bit brIn, input logic [15:0] tgtIn);
      bit          expReq;
      bit          sentValid;
      logic [15:0] sentData;
      @(negedge clk);
      expReq = mStarted && (mBuf.size() == 0);
      checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
      if (expReq) checkOutput("imem_addr", 32'(bus.imem_addr), 32'(mDraining ? mDrainAddr : mPc));
      rst_n         = rstIn;
      stall         = stallIn;
      branch_taken  = brIn;
      branch_target = tgtIn;
      sentValid = 1'b0;
      if (bus.imem_req === 1'b1) begin
         if (!memActive) begin
            memActive  = 1'b1;
            memCnt     = 0;
            memTxnAddr = bus.imem_addr;
            memWaitCur = (memFixedWait >= 0) ? memFixedWait : int'($urandom_range(memMaxWait, 0));
         end else begin
            checkOutput("addr_stable", 32'(bus.imem_addr), 32'(memTxnAddr));
         end
         sentValid = (memCnt >= memWaitCur);
      end
      sentData = sentValid ? memArr[bus.imem_addr[8:1]] : 16'($urandom);
      bus.imem_valid = sentValid;
      bus.imem_rdata = sentData;
      @(posedge clk);
      modelStep(rstIn, stallIn, brIn, tgtIn, sentValid, sentData);
      if (memActive) begin
         if (!rstIn || sentValid) memActive = 1'b0;
         else memCnt++;
      end
      #1;
      checkOutput("if_id_valid", 32'(if_id_valid), 32'(mIfValid));
      checkOutput("if_id_instr", 32'(if_id_instr), 32'(mIfInstr));
      checkOutput("if_id_pc_next", 32'(if_id_pc_next), 32'(mIfPcNext));
   endtask

   // Directed scenarios followed by a long randomized run.
   initial begin
      for (int i = 0; i < 256; i++) memArr[i] = 16'($urandom);
      memArr[0] = 16'h1123;
      memArr[1] = 16'h9245;
      memArr[2] = 16'hC301;
      memActive      = 1'b0;
      rst_n          = 1'b0;
      stall          = 1'b0;
      branch_taken   = 1'b0;
      branch_target  = 16'h0000;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 16'h0000;
      modelReset();
      repeat (2) @(posedge clk);

      // Reset, then a zero-wait stream of three instructions.
      memFixedWait = 0;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("first_instr", 32'(if_id_instr), 32'h1123);
      checkOutput("first_pc_next", 32'(if_id_pc_next), 32'h0002);
      checkOutput("first_valid", 32'(if_id_valid), 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("second_instr", 32'(if_id_instr), 32'h9245);
      checkOutput("second_pc_next", 32'(if_id_pc_next), 32'h0004);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("third_instr", 32'(if_id_instr), 32'hC301);
      checkOutput("third_pc_next", 32'(if_id_pc_next), 32'h0006);

      // Two wait states per fetch.
      memFixedWait = 2;
      repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

      // Stall for three cycles while a response returns.
      memFixedWait = 0;
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      checkOutput("hold_req", 32'(bus.imem_req), 32'h0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

      // Branch to 0x0041 while the fetch at 0x0010 is still pending.
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0010);
      memFixedWait = 3;
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0041);
      checkOutput("drain_if_valid", 32'(if_id_valid), 32'h0);
      memFixedWait = 0;
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

      // Branch and stall together while holding a buffered instruction.
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0200);
      checkOutput("flush_if_valid", 32'(if_id_valid), 32'h0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

      // Fetch at 0xFFFE wraps, then reset arrives mid-request.
      applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("wrap_pc_next", 32'(if_id_pc_next), 32'h0000);
      checkOutput("wrap_valid", 32'(if_id_valid), 32'h1);
      memFixedWait = 3;
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("reset_valid", 32'(if_id_valid), 32'h0);
      checkOutput("reset_instr", 32'(if_id_instr), 32'h0);
      memFixedWait = 0;
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

      // Randomized traffic with random wait states, stalls, branches and resets.
      memFixedWait = -1;
      memMaxWait   = 3;
      for (int n = 0; n < 2000; n++) begin
         applyStimulus($urandom_range(99, 0) != 0,
                       $urandom_range(3, 0) == 0,
                       $urandom_range(11, 0) == 0,
                       16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
